multicycle_controller: RTL and testbench

Multi-cycle sequencing FSM for the single-issue RV64I-subset core. It walks each instruction through fetch, decode, execute, memory and write-back steps, and drives the datapath strobes that enable each step. It also produces the 2-bit `ALUOp` consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode from funct. It sits between the instruction register / unified memory port and the shared register file / ALU datapath.

---
 rtl/multicycle_controller_if.sv | 28 ++
 rtl/multicycle_controller.sv | 97 +++++++++
 tb/tb_multicycle_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: sequencing strobes between the controller and the datapath/memory port.
interface multicycle_controller_if #(parameter int COUNT_W = 16);
   logic               run;
   logic [6:0]         opcode;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic               ir_write;
   logic               mem_read;
   logic               mem_write;
   logic               reg_write;
   logic               alu_src;
   logic               mem_to_reg;
   logic [1:0]         ALUOp;
   logic [2:0]         state;
   logic               illegal;
   logic [COUNT_W-1:0] instr_count;
   modport master (
      input  run, opcode, zero, mem_ready,
      output pc_write, ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg,
             ALUOp, state, illegal, instr_count
   );
   modport slave (
      output run, opcode, zero, mem_ready,
      input  pc_write, ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg,
             ALUOp, state, illegal, instr_count
   );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/exec/mem/write-back sequencer for the RV64I-subset core.
module multicycle_controller #(
   parameter int COUNT_W = 16
) (
   input logic                    clk,
   input logic                    reset_n,
   multicycle_controller_if.master bus
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, ERR = 3'd5} state_t;
   typedef enum logic [1:0] {C_R, C_LD, C_SD, C_BEQ} cls_t;
   state_t             state_q;
   cls_t               cls_q;
   logic               illegal_q;
   logic [COUNT_W-1:0] cnt_q;
   logic               known;
   cls_t               dec_cls;
   logic               retire;
   always_comb begin
      known   = 1'b1;
      dec_cls = C_R;
      case (bus.opcode)
         7'b0110011: dec_cls = C_R;
         7'b0000011: dec_cls = C_LD;
         7'b0100011: dec_cls = C_SD;
         7'b1100011: dec_cls = C_BEQ;
         default:    known = 1'b0;
      endcase
   end
   assign retire = (state_q == EXEC && cls_q == C_BEQ) ||
                   (state_q == MEM && cls_q == C_SD && bus.mem_ready) ||
                   (state_q == WB);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FETCH;
         cls_q     <= C_R;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (retire) cnt_q <= cnt_q + 1'b1;
         case (state_q)
            FETCH:  if (bus.run && bus.mem_ready) state_q <= DECODE;
            DECODE: begin
               if (known) begin
                  cls_q   <= dec_cls;
                  state_q <= EXEC;
               end else begin
                  illegal_q <= 1'b1;
                  state_q   <= ERR;
               end
            end
            EXEC:   state_q <= cls_q == C_R ? WB : cls_q == C_BEQ ? FETCH : MEM;
            MEM:    if (bus.mem_ready) state_q <= cls_q == C_LD ? WB : FETCH;
            WB:     state_q <= FETCH;
            ERR:    state_q <= ERR;
            default: state_q <= FETCH;
         endcase
      end
   end
   // Strobes are gated by reset_n so they drop the instant reset asserts, even in FETCH with run high.
   always_comb begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.ALUOp      = 2'b00;
      if (reset_n)
         case (state_q)
            FETCH: if (bus.run) begin
               bus.mem_read = 1'b1;
               bus.alu_src  = 1'b1;
               bus.ir_write = bus.mem_ready;
               bus.pc_write = bus.mem_ready;
            end
            EXEC: begin
               bus.ALUOp    = cls_q == C_R ? 2'b10 : cls_q == C_BEQ ? 2'b01 : 2'b00;
               bus.alu_src  = cls_q == C_LD || cls_q == C_SD;
               bus.pc_write = cls_q == C_BEQ && bus.zero;
            end
            MEM: begin
               bus.mem_read  = cls_q == C_LD;
               bus.mem_write = cls_q == C_SD;
               bus.alu_src   = 1'b1;
            end
            WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = cls_q == C_LD;
            end
            default: ;
         endcase
   end
   assign bus.state       = state_q;
   assign bus.illegal     = illegal_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction expected traces built from the latency/strobe rules, checked every cycle.
module tb_multicycle_controller;
   localparam int W = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   multicycle_controller_if #(.COUNT_W(W)) bus();
   multicycle_controller #(.COUNT_W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   typedef struct packed {
      logic [2:0] st;
      logic pc, ir, mr, mw, rw, as, m2r;
      logic [1:0] op;
      logic ill;
      logic [W-1:0] cnt;
   } exp_t;
   typedef struct {
      logic run, rdy, z;
      logic [6:0] opc;
      exp_t e;
   } cyc_t;
   cyc_t plan[$];
   logic [2:0] seen[$];
   int tests = 0;
   int fails = 0;
   logic [W-1:0] mcnt = '0;
   logic mill = 1'b0;
   logic [W-1:0] c0;
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction
   function automatic logic [6:0] r7();
      return 7'($urandom);
   endfunction
   function automatic exp_t mk(logic [2:0] st, logic pc, logic ir, logic mr, logic mw, logic rw,
                               logic as, logic m2r, logic [1:0] op);
      return '{st, pc, ir, mr, mw, rw, as, m2r, op, mill, mcnt};
   endfunction
   task automatic push(logic r, logic m, logic z, logic [6:0] o, exp_t e);
      cyc_t c;
      c.run = r; c.rdy = m; c.z = z; c.opc = o; c.e = e;
      plan.push_back(c);
   endtask
   // Class codes: 0 R, 1 LD, 2 SD, 3 BEQ, 4 illegal.
   task automatic add_instr(int c, int fs, int ms, logic z, int idle, int nerr);
      logic [6:0] opc;
      opc = c == 0 ? 7'b0110011 : c == 1 ? 7'b0000011 : c == 2 ? 7'b0100011 :
            c == 3 ? 7'b1100011 : 7'b1111111;
      for (int i = 0; i < idle; i++) push(1'b0, rb(), rb(), r7(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < fs; i++) push(1'b1, 1'b0, rb(), r7(), mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
      push(1'b1, 1'b1, rb(), r7(), mk(0, 1, 1, 1, 0, 0, 1, 0, 0));
      push(rb(), rb(), rb(), opc, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (c == 4) begin
         mill = 1'b1;
         for (int i = 0; i < nerr; i++) push(rb(), rb(), rb(), r7(), mk(5, 0, 0, 0, 0, 0, 0, 0, 0));
         return;
      end
      case (c)
         0: begin
            push(rb(), rb(), rb(), r7(), mk(2, 0, 0, 0, 0, 0, 0, 0, 2'b10));
            push(rb(), rb(), rb(), r7(), mk(4, 0, 0, 0, 0, 1, 0, 0, 0));
         end
         1, 2: begin
            push(rb(), rb(), rb(), r7(), mk(2, 0, 0, 0, 0, 0, 1, 0, 0));
            for (int i = 0; i <= ms; i++)
               push(rb(), i == ms, rb(), r7(), mk(3, 0, 0, c == 1, c == 2, 0, 1, 0, 0));
            if (c == 1) push(rb(), rb(), rb(), r7(), mk(4, 0, 0, 0, 0, 1, 0, 1, 0));
         end
         default: push(rb(), rb(), z, r7(), mk(2, z, 0, 0, 0, 0, 0, 0, 2'b01));
      endcase
      mcnt = mcnt + 1'b1;
   endtask
   task automatic run_plan(int n);
      cyc_t c;
      exp_t act;
      for (int k = 0; k < n && plan.size() > 0; k++) begin
         c = plan.pop_front();
         @(negedge clk);
         bus.run = c.run; bus.mem_ready = c.rdy; bus.zero = c.z; bus.opcode = c.opc;
         #2;
         act = {bus.state, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                bus.alu_src, bus.mem_to_reg, bus.ALUOp, bus.illegal, bus.instr_count};
         seen.push_back(bus.state);
         tests++;
         if (act !== c.e) begin
            fails++;
            $display("FAIL trace t=%0t got %h want %h (st,pc,ir,mr,mw,rw,as,m2r,op,ill,cnt)", $time, act, c.e);
         end
      end
   endtask
   task automatic lit(string nm, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got %0h want %0h", nm, a, e);
      end
   endtask
   task automatic idle_cycle();
      @(negedge clk);
      bus.run = 1'b0;
      #2;
   endtask
   task automatic release_reset();
      bus.run = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask
   initial begin
      bus.run = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.opcode = 7'b0110011;
      #3;
      lit("rst_state", 32'(bus.state), 0);
      lit("rst_mem_read", 32'(bus.mem_read), 0);
      lit("rst_ir_write", 32'(bus.ir_write), 0);
      lit("rst_cnt", 32'(bus.instr_count), 0);
      lit("rst_illegal", 32'(bus.illegal), 0);
      release_reset();
      seen.delete();
      add_instr(0, 0, 0, 1'b0, 0, 0);
      run_plan(100);
      lit("r_states", 32'({seen[0], seen[1], seen[2], seen[3]}), 32'b000_001_010_100);
      lit("r_cycles", seen.size(), 4);
      idle_cycle();
      lit("r_count", 32'(bus.instr_count), 1);
      seen.delete();
      add_instr(1, 0, 2, 1'b0, 0, 0);
      run_plan(100);
      lit("ld_cycles", seen.size(), 7);
      idle_cycle();
      lit("ld_count", 32'(bus.instr_count), 2);
      add_instr(3, 0, 0, 1'b1, 0, 0);
      add_instr(3, 1, 0, 1'b0, 1, 0);
      add_instr(2, 2, 1, 1'b0, 2, 0);
      run_plan(1000);
      for (int i = 0; i < 60; i++)
         add_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                   $urandom_range(0, 2), 0);
      run_plan(10000);
      reset_n = 1'b0; mcnt = '0; mill = 1'b0;
      release_reset();
      for (int i = 0; i < 17; i++) add_instr(2, 0, 0, 1'b0, 0, 0);
      run_plan(1000);
      idle_cycle();
      lit("wrap_count", 32'(bus.instr_count), 1);
      c0 = mcnt;
      add_instr(2, 0, 3, 1'b0, 0, 0);
      run_plan(4);
      plan.delete();
      lit("pre_rst_mem_write", 32'(bus.mem_write), 1);
      lit("pre_rst_count", 32'(bus.instr_count), 32'(c0));
      reset_n = 1'b0; mcnt = '0; mill = 1'b0;
      #1;
      lit("rst_mem_write", 32'(bus.mem_write), 0);
      lit("rst_mid_count", 32'(bus.instr_count), 0);
      lit("rst_mid_state", 32'(bus.state), 0);
      release_reset();
      add_instr(4, 1, 0, 1'b0, 1, 6);
      run_plan(100);
      lit("err_illegal", 32'(bus.illegal), 1);
      reset_n = 1'b0; mcnt = '0; mill = 1'b0;
      #1;
      lit("err_rst_illegal", 32'(bus.illegal), 0);
      lit("err_rst_state", 32'(bus.state), 0);
      release_reset();
      add_instr(0, 0, 0, 1'b0, 0, 0);
      add_instr(1, 1, 1, 1'b0, 0, 0);
      run_plan(100);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
